// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and tag layout helpers for the forwarding / load-use hazard unit.
// Tag entry bit layout (MSB..LSB): {valid, regwr, is_load, aw[REG_ADDR_W-1:0]}.
package fwd_pkg;

   localparam int unsigned SEL_RF     = 0;
   localparam int unsigned TAG_FLAGS  = 3;

   function automatic int unsigned sel_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w);
      return addr_w + TAG_FLAGS;
   endfunction

   function automatic int unsigned tag_load_bit(input int unsigned addr_w);
      return addr_w;
   endfunction

   function automatic int unsigned tag_regwr_bit(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

   function automatic int unsigned tag_valid_bit(input int unsigned addr_w);
      return addr_w + 2;
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_src_match.sv
// Per-source bypass selection: youngest matching in-flight writer wins, else register file.
module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FWD_DEPTH  = 3,
   parameter int unsigned SEL_W      = 2
) (
   input  logic [REG_ADDR_W-1:0]                  src_addr,
   input  logic                                   src_used,
   input  logic [FWD_DEPTH*tag_w(REG_ADDR_W)-1:0] tags,
   input  logic [FWD_DEPTH*DATA_W-1:0]            stage_data,
   input  logic [DATA_W-1:0]                      rf_data,
   output logic [SEL_W-1:0]                       sel,
   output logic [DATA_W-1:0]                      data,
   output logic                                   load_hit
);

   localparam int unsigned TW = tag_w(REG_ADDR_W);

   logic [FWD_DEPTH-1:0] hit;
   logic                 found;
   logic                 picked_load;

   always_comb begin
      hit = '0;
      for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
         hit[k] = src_used && (src_addr != '0)
                  && tags[k*TW + tag_valid_bit(REG_ADDR_W)]
                  && tags[k*TW + tag_regwr_bit(REG_ADDR_W)]
                  && (tags[k*TW +: REG_ADDR_W] == src_addr);
      end
   end

   always_comb begin
      sel         = SEL_W'(SEL_RF);
      data        = rf_data;
      found       = 1'b0;
      picked_load = 1'b0;
      for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
         if (!found && hit[k]) begin
            found       = 1'b1;
            sel         = SEL_W'(k + 1);
            data        = stage_data[k*DATA_W +: DATA_W];
            picked_load = tags[k*TW + tag_load_bit(REG_ADDR_W)];
         end
      end
      // A load still in Ex is always the youngest hit, so this equals Match(0) & is_load(0)
      load_hit = picked_load && (sel == SEL_W'(1));
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: in-flight destination tag shift register plus per-source bypass.
// Optional feature: define FWD_STALL_CNT_EN to add the stall_cnt port and load-use stall counter.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned FWD_DEPTH  = 3
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0]       id_src_addr,
   input  logic [NUM_SRC-1:0]                  id_src_used,
   input  logic [REG_ADDR_W-1:0]               id_aw,
   input  logic                                id_regwr,
   input  logic                                id_is_load,
   input  logic                                ext_stall,
   input  logic                                flush,
   input  logic [NUM_SRC*DATA_W-1:0]           rf_data,
   input  logic [FWD_DEPTH*DATA_W-1:0]         stage_data,
   output logic [NUM_SRC*sel_w(FWD_DEPTH)-1:0] fwd_sel,
   output logic [NUM_SRC*DATA_W-1:0]           fwd_data,
   output logic                                load_use_stall
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [31:0]                         stall_cnt
`endif
);

   localparam int unsigned TW    = tag_w(REG_ADDR_W);
   localparam int unsigned SEL_W = sel_w(FWD_DEPTH);

   logic [FWD_DEPTH*TW-1:0] tags;
   logic [TW-1:0]           new_tag;
   logic [NUM_SRC-1:0]      load_hit;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_match #(
         .REG_ADDR_W (REG_ADDR_W),
         .DATA_W     (DATA_W),
         .FWD_DEPTH  (FWD_DEPTH),
         .SEL_W      (SEL_W)
      ) u_match (
         .src_addr   (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
         .src_used   (id_src_used[i]),
         .tags       (tags),
         .stage_data (stage_data),
         .rf_data    (rf_data[i*DATA_W +: DATA_W]),
         .sel        (fwd_sel[i*SEL_W +: SEL_W]),
         .data       (fwd_data[i*DATA_W +: DATA_W]),
         .load_hit   (load_hit[i])
      );
   end

   always_comb begin
      load_use_stall = id_valid && !flush && (|load_hit);
      new_tag        = '0;
      if (id_valid && !flush && !load_use_stall) begin
         new_tag = {1'b1, id_regwr, id_is_load, id_aw};
      end
   end

   // ext_stall freezes every entry, which also defers any flush/load-use bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         tags <= '0;
      end else if (!ext_stall) begin
         tags[0 +: TW] <= new_tag;
         for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
            tags[k*TW +: TW] <= tags[(k-1)*TW +: TW];
         end
      end
   end

`ifdef FWD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (load_use_stall && !ext_stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
